detector_event_unpacker: RTL and testbench
==========================================

DETECTOR_EVENT_UNPACKER -- requirements
Module: detector_event_unpacker

Interface
REQ-001 SHALL have parameter CRC_BITS, default 5, number of framing bits at the top of the event word.
REQ-002 SHALL have parameter ID_BITS, default 6, block identifier width.
REQ-003 SHALL have parameter DATA_BITS, default 128, event word width.
REQ-004 SHALL have parameter OUT_BITS, default 16, output beat width; DATA_BITS and 48 SHALL be multiples of OUT_BITS.
REQ-005 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  event word valid from the detector front end.
REQ-008 SHALL have port in_ready  output  1  unpacker can accept an event word.
REQ-009 SHALL have port in_data  input  DATA_BITS  event word: [127:123] framing, [122] single-event flag, [121:116] block id, [115:20] eight 12-bit energies, [19:0] time tag.
REQ-010 SHALL have port in_period  input  48  period tag qualified by in_valid.
REQ-011 SHALL have port out_valid  output  1  output beat valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-013 SHALL have port out_data  output  OUT_BITS  output beat.
REQ-014 SHALL have port out_last  output  1  final beat of an event.
REQ-015 SHALL have port frame_err_count  output  16  rejected-word count.
REQ-016 SHALL have port event_count  output  32  fully transmitted event count.

Function
REQ-017 SHALL implement states IDLE and SEND; in_ready SHALL be 1 exactly in IDLE.
REQ-018 SHALL accept a word on a clk edge where in_valid and in_ready are both 1.
REQ-019 SHALL treat an accepted word as valid iff in_data[127:123] is all ones and in_data[122] is 1.
REQ-020 SHALL on a valid word capture in_data and in_period into a holding register and enter SEND on that edge.
REQ-021 SHALL on an invalid word discard it, stay in IDLE, and increment frame_err_count, saturating at 0xFFFF.
REQ-022 SHALL assert out_valid the cycle after acceptance (latency 1), and hold it through SEND.
REQ-023 SHALL emit 11 beats in order: beats 0-7 = in_data[127:112] down to [15:0]; beats 8-10 = in_period[47:32], [31:16], [15:0].
REQ-024 SHALL advance the beat index (0..10) only on out_valid and out_ready; out_data and out_last SHALL stay stable while out_valid and not out_ready.
REQ-025 SHALL assert out_last only during beat 10.
REQ-026 SHALL on acceptance of beat 10 return to IDLE, reset beat index to 0, and increment event_count (wraps modulo 2^32).
REQ-027 SHALL deassert in_ready on the edge that enters SEND; a back-to-back word is accepted no earlier than the cycle after beat 10 is accepted.
REQ-028 SHALL never deassert out_valid before the current beat is accepted.
REQ-029 SHALL ignore in_data and in_period when not accepting.

Reset
REQ-030 SHALL on rst low immediately force state IDLE, beat index 0, out_valid 0, out_last 0, out_data 0, holding register 0, frame_err_count 0, event_count 0.
REQ-031 SHALL drive in_ready 1 after rst deasserts.
REQ-032 SHALL on rst asserted mid-SEND abandon the event without incrementing event_count; no partial beats SHALL follow reset release.

Verification
REQ-033 Single event: in_data = {5'b11111,1'b1,6'd5,96'h0,20'hABCDE}, in_period=48'h123456789ABC, out_ready=1 -> 11 consecutive beats from cycle N+1, beat 0 = 0xFC50, beat 7 = 0xBCDE, beats 8-10 = 0x1234,0x5678,0x9ABC, out_last on beat 10 only, event_count=1.
REQ-034 Bad framing: in_data[127:123]=5'b11110 -> no out_valid, frame_err_count=1, in_ready stays 1; then 0xFFFF preset by 65535 bad words plus one more -> stays 0xFFFF.
REQ-035 Backpressure: out_ready toggled 1,0,0,1 per cycle during SEND -> each beat held stable while out_ready=0, all 11 beats delivered exactly once in order.
REQ-036 Back-to-back: in_valid held 1 with two valid words -> second accepted only after first event's beat 10 accepted; 22 beats, event_count=2.
REQ-037 Reset mid-SEND: rst low at beat 4 -> out_valid 0 asynchronously, counters 0, after release in_ready=1 and no residual beats.
REQ-038 Flag clear: framing ones but in_data[122]=0 -> rejected, frame_err_count increments, event_count unchanged.

Source files
------------

// File: rtl/detector_event_unpacker.sv
// Unpacks a framed detector event word plus its period tag into a stream of
// fixed-width output beats, rejecting words whose framing bits are not all set.
module detector_event_unpacker #(
  parameter int CRC_BITS  = 5,
  parameter int ID_BITS   = 6,
  parameter int DATA_BITS = 128,
  parameter int OUT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic [47:0]          in_period,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_BITS-1:0]  out_data,
  output logic                 out_last,
  output logic [15:0]          frame_err_count,
  output logic [31:0]          event_count
);

  localparam int PERIOD_BITS = 48;
  localparam int HOLD_BITS   = DATA_BITS + PERIOD_BITS;
  localparam int NUM_BEATS   = HOLD_BITS / OUT_BITS;
  localparam int IDX_BITS    = $clog2(NUM_BEATS);
  localparam int FLAG_POS    = DATA_BITS - CRC_BITS - 1;
  localparam int ID_LSB      = FLAG_POS - ID_BITS;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_BEATS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]           state;
  logic [IDX_BITS-1:0]  beat_idx;
  logic [HOLD_BITS-1:0] hold_reg;
  logic [DATA_BITS-1:0] event_word;
  logic                 word_ok;
  logic                 accept;
  logic                 beat_done;
  logic                 last_beat;

  // Header (framing + flag), block id and payload are reassembled in wire order
  assign event_word = {in_data[DATA_BITS-1:FLAG_POS],
                       in_data[ID_LSB +: ID_BITS],
                       in_data[ID_LSB-1:0]};
  assign word_ok    = (&in_data[DATA_BITS-1 -: CRC_BITS]) && in_data[FLAG_POS];

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == SEND);
  assign accept     = in_valid && in_ready;
  assign beat_done  = out_valid && out_ready;
  assign last_beat  = (beat_idx == LAST_IDX);
  assign out_last   = out_valid && last_beat;
  // The holding register shifts one beat per handshake, so the top slice is always the current beat
  assign out_data   = hold_reg[HOLD_BITS-1 -: OUT_BITS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      beat_idx        <= '0;
      hold_reg        <= '0;
      frame_err_count <= '0;
      event_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (word_ok) begin
              hold_reg <= {event_word, in_period};
              beat_idx <= '0;
              state    <= SEND;
            end else if (frame_err_count != 16'hFFFF) begin
              frame_err_count <= frame_err_count + 16'd1;
            end
          end
        end
        SEND: begin
          if (beat_done) begin
            hold_reg <= hold_reg << OUT_BITS;
            if (last_beat) begin
              beat_idx    <= '0;
              event_count <= event_count + 32'd1;
              state       <= IDLE;
            end else begin
              beat_idx <= beat_idx + IDX_BITS'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          beat_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_detector_event_unpacker.sv
// Self-checking bench for detector_event_unpacker: directed cases plus random
// traffic compared against a queue-based model of the expected beat stream.
module tb_detector_event_unpacker;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [47:0]  in_period;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic         out_last;
  logic [15:0]  frame_err_count;
  logic [31:0]  event_count;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  logic [15:0] model_err = '0;
  logic [31:0] model_events = '0;
  bit          accepted_last;

  detector_event_unpacker dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_period(in_period),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .frame_err_count(frame_err_count),
    .event_count(event_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit framing_ok(input logic [127:0] d);
    return (d[127:123] == 5'b11111) && d[122];
  endfunction

  // An event is the 176-bit concatenation of word and period, sent MSB first in 16-bit slices
  task automatic push_event(input logic [127:0] d, input logic [47:0] p);
    logic [175:0] w;
    w = {d, p};
    for (int i = 0; i < 11; i++) exp_q.push_back({(i == 10), w[175 - 16*i -: 16]});
  endtask

  function automatic logic [127:0] rand_word(input bit good);
    logic [127:0] d;
    int k;
    d = {$urandom, $urandom, $urandom, $urandom};
    d[127:122] = 6'h3F;
    if (!good) begin
      k = $urandom_range(0, 5);
      d[127 - k] = 1'b0;
    end
    return d;
  endfunction

  task automatic apply_stimulus();
    logic [16:0] front;
    #4;
    accepted_last = 1'b0;
    check_output("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check_output("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
    if (out_valid && exp_q.size() != 0) begin
      front = exp_q[0];
      check_output("out_data", 32'(out_data), 32'(front[15:0]));
      check_output("out_last", 32'(out_last), 32'(front[16]));
      if (out_ready) begin
        if (front[16]) model_events++;
        void'(exp_q.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      accepted_last = 1'b1;
      if (framing_ok(in_data)) push_event(in_data, in_period);
      else if (model_err != 16'hFFFF) model_err++;
    end
    @(posedge clk);
    #1;
    check_output("frame_err_count", 32'(frame_err_count), 32'(model_err));
    check_output("event_count", event_count, model_events);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      apply_stimulus();
      n++;
    end
    check_output("drain_timeout", 32'(exp_q.size()), 32'd0);
    apply_stimulus();
  endtask

  initial begin
    logic [127:0] word_a;
    logic [127:0] word_b;
    logic [31:0]  ev0;
    bit   [3:0]   pat;
    int           k;
    int           accepts;

    in_valid  = 1'b0;
    in_data   = '0;
    in_period = '0;
    out_ready = 1'b0;

    #3;
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_last", 32'(out_last), 32'd0);
    check_output("rst_out_data", 32'(out_data), 32'd0);
    check_output("rst_frame_err", 32'(frame_err_count), 32'd0);
    check_output("rst_event_count", event_count, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Single event with a fixed word
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {5'b11111, 1'b1, 6'd5, 96'h0, 20'hABCDE};
    in_period = 48'h123456789ABC;
    apply_stimulus();
    in_valid = 1'b0;
    in_data  = rand_word(1'b1);
    #4;
    check_output("first_beat_const", 32'(out_data), 32'h0000FC50);
    @(posedge clk);
    #1;
    void'(exp_q.pop_front());
    model_events = model_events;
    drain();
    check_output("single_event_count", event_count, 32'd1);

    // Bad framing, then framing ones with the flag clear
    in_valid = 1'b1;
    in_data  = {5'b11110, 1'b1, 122'h0};
    apply_stimulus();
    in_data  = {5'b11111, 1'b0, 6'd9, 116'h1234};
    apply_stimulus();
    in_valid = 1'b0;
    apply_stimulus();
    check_output("bad_word_errs", 32'(frame_err_count), 32'd2);

    // Backpressure with out_ready pattern 1,0,0,1
    pat       = 4'b1001;
    in_valid  = 1'b1;
    in_data   = rand_word(1'b1);
    in_period = {$urandom, $urandom};
    apply_stimulus();
    in_valid = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      out_ready = pat[3 - (k % 4)];
      apply_stimulus();
      k++;
    end
    check_output("backpressure_timeout", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b1;

    // Back-to-back words with in_valid held high
    ev0       = model_events;
    word_a    = rand_word(1'b1);
    word_b    = rand_word(1'b1);
    in_data   = word_a;
    in_period = {$urandom, $urandom};
    in_valid  = 1'b1;
    accepts   = 0;
    k         = 0;
    while (accepts < 2 && k < 100) begin
      apply_stimulus();
      if (accepted_last) begin
        accepts++;
        in_data   = word_b;
        in_period = {$urandom, $urandom};
      end
      if (accepts == 2) in_valid = 1'b0;
      k++;
    end
    drain();
    check_output("b2b_events", event_count, ev0 + 32'd2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = rand_word($urandom_range(0, 3) != 0);
      in_period = {$urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      apply_stimulus();
    end
    out_ready = 1'b1;
    drain();

    // Reset in the middle of an event
    in_valid  = 1'b1;
    in_data   = rand_word(1'b1);
    in_period = {$urandom, $urandom};
    apply_stimulus();
    in_valid = 1'b0;
    k = 0;
    while (exp_q.size() > 7 && k < 50) begin
      apply_stimulus();
      k++;
    end
    #1 rst = 1'b0;
    #1;
    check_output("midrst_out_valid", 32'(out_valid), 32'd0);
    check_output("midrst_out_last", 32'(out_last), 32'd0);
    check_output("midrst_out_data", 32'(out_data), 32'd0);
    check_output("midrst_frame_err", 32'(frame_err_count), 32'd0);
    check_output("midrst_event_count", event_count, 32'd0);
    exp_q.delete();
    model_err    = '0;
    model_events = '0;
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) apply_stimulus();

    // Error counter saturation
    in_valid = 1'b1;
    in_data  = {5'b11110, 1'b1, 122'h0};
    repeat (65537) apply_stimulus();
    in_valid = 1'b0;
    apply_stimulus();
    check_output("err_saturated", 32'(frame_err_count), 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
